// File: rtl/pattern_scan_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scan_pkg
// Purpose : shared types and reset-default constants for the programmable
//           serial pattern scanner.
// Contents: state_t      - controller state encoding (IDLE, SCAN, DONE)
//           DEF_PAT      - pattern loaded at reset ('b101)
//           DEF_LEN      - pattern length loaded at reset (3)
//           DEF_OVL      - overlap mode loaded at reset (1 = overlapping)
// -----------------------------------------------------------------------------
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int   DEF_PAT = 'b101;
   localparam int   DEF_LEN = 3;
   localparam logic DEF_OVL = 1'b1;

endpackage

// File: rtl/pattern_scan_ctrl_window.sv
// -----------------------------------------------------------------------------
// pattern_window
// Purpose : serial shift window, history counter and length-masked compare
//           against the programmed pattern. The match output is combinational
//           and includes the bit currently presented on i_x.
// Ports   : clk      - clock, state updates on the falling edge
//           rst      - asynchronous active-low reset
//           i_clear  - clear window and history (frame start)
//           i_shift  - accept i_x into the window this cycle
//           i_x      - serial data bit
//           i_pat    - pattern, bit [len-1] is the oldest expected bit
//           i_len    - pattern length (already clamped to 1..MAX_LEN)
//           i_ovl    - 1 = overlapping matches, 0 = non-overlapping
//           o_match  - window including i_x equals the pattern
// -----------------------------------------------------------------------------
module pattern_window
   import pattern_scan_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_shift,
   input  logic               i_x,
   input  logic [MAX_LEN-1:0] i_pat,
   input  logic [LW-1:0]      i_len,
   input  logic               i_ovl,
   output logic               o_match
);

   logic [MAX_LEN-1:0] r_win;
   logic [LW-1:0]      r_hist;
   logic [MAX_LEN-1:0] w_nwin;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_hist_ok;

   // Newest bit enters at the LSB, so the last len bits sit in w_nwin[len-1:0].
   assign w_nwin = {r_win[MAX_LEN-2:0], i_x};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(i_len));
      end
   end

   // r_hist counts bits usable for the next match; +1 accounts for i_x itself.
   assign w_hist_ok = (({1'b0, r_hist} + 1'b1) >= {1'b0, i_len});
   assign o_match   = w_hist_ok && (((w_nwin ^ i_pat) & w_mask) == '0);

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_win  <= '0;
         r_hist <= '0;
      end else if (i_clear) begin
         r_win  <= '0;
         r_hist <= '0;
      end else if (i_shift) begin
         r_win <= w_nwin;
         // Non-overlapping mode: bits of a match may not seed the next one.
         if (o_match && !i_ovl) begin
            r_hist <= '0;
         end else if (r_hist != LW'(MAX_LEN)) begin
            r_hist <= r_hist + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
// Purpose : programmable serial sequence detector. Holds a run-time pattern,
//           scans a frame of frame_len serial bits, flags matches on q and
//           counts them (saturating) in match_cnt.
// Ports   : clk, rst            - falling-edge clock, async active-low reset
//           cfg_we/pat/len/ovl  - configuration load, honoured only in IDLE
//           start, frame_len    - begin a frame, honoured only in IDLE
//           x_valid, x          - serial input stream
//           busy                - high in SCAN and DONE
//           q                   - Mealy match flag for the current bit
//           match_cnt           - matches in current/last frame
//           done                - one-cycle end-of-frame pulse
//           dbg_state           - current controller state (observability)
// Handshake: a bit is consumed on every falling edge where the controller is
//           in SCAN and x_valid is high; there is no back-pressure.
// -----------------------------------------------------------------------------
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int  MAX_LEN = 8,
   parameter int  CNT_W   = 8,
   parameter int  FRAME_W = 8,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_ovl,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_len,
   input  logic               x_valid,
   input  logic               x,
   output logic               busy,
   output logic               q,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               done,
   output state_t             dbg_state
);

   state_t             r_state;
   logic [MAX_LEN-1:0] r_pat;
   logic [LW-1:0]      r_len;
   logic               r_ovl;
   logic [FRAME_W-1:0] r_frame_len;
   logic [FRAME_W-1:0] r_bitcnt;
   logic [CNT_W-1:0]   r_match_cnt;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_clear;
   logic               w_match;
   logic [FRAME_W-1:0] w_bitcnt_nxt;
   logic [LW-1:0]      w_len_clamped;

   assign w_accept     = (r_state == SCAN) && x_valid;
   assign w_clear      = (r_state == IDLE) && start;
   assign w_bitcnt_nxt = r_bitcnt + 1'b1;

   always_comb begin
      w_len_clamped = cfg_len;
      if (cfg_len == '0) begin
         w_len_clamped = LW'(1);
      end else if (cfg_len > LW'(MAX_LEN)) begin
         w_len_clamped = LW'(MAX_LEN);
      end
   end

   pattern_window #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_window (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_shift (w_accept),
      .i_x     (x),
      .i_pat   (r_pat),
      .i_len   (r_len),
      .i_ovl   (r_ovl),
      .o_match (w_match)
   );

   assign q         = w_accept && w_match;
   assign busy      = r_busy;
   assign done      = r_done;
   assign match_cnt = r_match_cnt;
   assign dbg_state = r_state;

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_pat       <= MAX_LEN'(DEF_PAT);
         r_len       <= LW'(DEF_LEN);
         r_ovl       <= DEF_OVL;
         r_frame_len <= '0;
         r_bitcnt    <= '0;
         r_match_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Config loads on the same edge as start, so it applies to this frame.
               if (cfg_we) begin
                  r_pat <= cfg_pat;
                  r_len <= w_len_clamped;
                  r_ovl <= cfg_ovl;
               end
               if (start) begin
                  r_frame_len <= frame_len;
                  r_bitcnt    <= '0;
                  r_match_cnt <= '0;
                  r_busy      <= 1'b1;
                  if (frame_len == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (x_valid) begin
                  r_bitcnt <= w_bitcnt_nxt;
                  if (w_match && (r_match_cnt != '1)) begin
                     r_match_cnt <= r_match_cnt + 1'b1;
                  end
                  if (w_bitcnt_nxt == r_frame_len) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Purpose : directed self-checking bench for pattern_scan_ctrl. Two instances
//           share all inputs: the default one (CNT_W=8) and a narrow-counter one
//           (CNT_W=2) used to observe counter saturation. Inputs change on the
//           rising edge; the design updates on the falling edge.
// -----------------------------------------------------------------------------
module tb_pattern_scan_ctrl;
   import pattern_scan_pkg::*;

   localparam int MAX_LEN = 8;
   localparam int LW      = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic               cfg_we = 1'b0;
   logic [MAX_LEN-1:0] cfg_pat = '0;
   logic [LW-1:0]      cfg_len = '0;
   logic               cfg_ovl = 1'b0;
   logic               start = 1'b0;
   logic [7:0]         frame_len = '0;
   logic               x_valid = 1'b0;
   logic               x = 1'b0;

   logic               busy, q, done;
   logic [7:0]         match_cnt;
   state_t             dbg_state;
   logic               busy2, q2, done2;
   logic [1:0]         match_cnt2;
   state_t             dbg_state2;

   pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(8), .FRAME_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl), .start(start), .frame_len(frame_len), .x_valid(x_valid),
      .x(x), .busy(busy), .q(q), .match_cnt(match_cnt), .done(done),
      .dbg_state(dbg_state)
   );

   pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(2), .FRAME_W(8)) dut2 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl), .start(start), .frame_len(frame_len), .x_valid(x_valid),
      .x(x), .busy(busy2), .q(q2), .match_cnt(match_cnt2), .done(done2),
      .dbg_state(dbg_state2)
   );

   // ---------------- scoreboard / model ----------------
   int          test_cnt = 0;
   int          fail_cnt = 0;
   logic [31:0] exp_q[$];

   logic [7:0]  m_pat;
   int          m_len;
   bit          m_ovl;
   bit          m_bits[$];
   int          m_last_end;
   int          m_cnt;
   int          m_cnt2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic model_cfg(input logic [7:0] pat, input int len, input bit ovl);
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
      m_ovl = ovl;
   endtask

   // Match ending at accepted bit n: the last m_len bits read oldest-first equal
   // pat[len-1..0], and (non-overlapping) none of them belong to an earlier match.
   function automatic bit model_match(input int n);
      if (n + 1 < m_len) return 1'b0;
      if (!m_ovl && (n - m_len + 1 <= m_last_end)) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         if (m_bits[n - m_len + 1 + k] != m_pat[m_len - 1 - k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl);
      @(posedge clk);
      cfg_we = 1'b1; cfg_pat = pat; cfg_len = LW'(len); cfg_ovl = ovl;
      model_cfg(pat, len, ovl);
      @(negedge clk); #1;
      cfg_we = 1'b0;
      check("cfg_state_idle", 32'(dbg_state), 32'(IDLE));
   endtask

   task automatic begin_frame(input bit we, input logic [7:0] pat, input int len,
                              input bit ovl, input int flen);
      @(posedge clk);
      cfg_we = we; cfg_pat = pat; cfg_len = LW'(len); cfg_ovl = ovl;
      start = 1'b1; frame_len = 8'(flen);
      if (we) model_cfg(pat, len, ovl);
      m_bits.delete(); m_last_end = -1; m_cnt = 0; m_cnt2 = 0;
      @(negedge clk); #1;
      cfg_we = 1'b0; start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_state", 32'(dbg_state), (flen == 0) ? 32'(DONE) : 32'(SCAN));
   endtask

   task automatic send_bit(input bit b, input string tag);
      int          n;
      bit          e;
      logic [31:0] got;
      @(posedge clk);
      x = b; x_valid = 1'b1;
      m_bits.push_back(b);
      n = m_bits.size() - 1;
      e = model_match(n);
      if (e) begin
         m_last_end = n;
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      exp_q.push_back(32'(e));
      #1;
      got = exp_q.pop_front();
      check({tag, "_q"}, 32'(q), got);
      check({tag, "_q2"}, 32'(q2), got);
   endtask

   task automatic gap(input string tag);
      @(posedge clk);
      x_valid = 1'b0; x = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_gap_q"}, 32'(q), 32'd0);
      check({tag, "_gap_cnt"}, 32'(match_cnt), 32'(m_cnt));
   endtask

   task automatic finish_frame(input string tag);
      @(posedge clk);
      x_valid = 1'b0;
      #1;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done2"}, 32'(done2), 32'd1);
      check({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
      check({tag, "_cnt2"}, 32'(match_cnt2), 32'(m_cnt2));
      @(posedge clk); #1;
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      check({tag, "_busy2_low"}, 32'(busy2), 32'd0);
      check({tag, "_cnt_hold"}, 32'(match_cnt), 32'(m_cnt));
      check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_q"}, 32'(q), 32'd0);
      check({tag, "_cnt"}, 32'(match_cnt), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
      check({tag, "_state2"}, 32'(dbg_state2), 32'(IDLE));
   endtask

   task automatic frame_10101(input string tag);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 5);
      send_bit(1'b1, tag); send_bit(1'b0, tag); send_bit(1'b1, tag);
      send_bit(1'b0, tag); send_bit(1'b1, tag);
      finish_frame(tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      model_cfg(8'(DEF_PAT), DEF_LEN, DEF_OVL);
      m_cnt = 0; m_cnt2 = 0; m_last_end = -1;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;

      // 1: reset defaults 101/3 overlapping -> matches on bits 3 and 5
      frame_10101("t1");

      // 2: non-overlapping, config loaded together with start -> one match
      begin_frame(1'b1, 8'b101, 3, 1'b0, 5);
      send_bit(1'b1, "t2"); send_bit(1'b0, "t2"); send_bit(1'b1, "t2");
      send_bit(1'b0, "t2"); send_bit(1'b1, "t2");
      finish_frame("t2");

      // 3: 1001/4 overlapping with idle gaps between bits
      do_cfg(8'b1001, 4, 1'b1);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 7);
      send_bit(1'b1, "t3"); gap("t3"); send_bit(1'b0, "t3"); gap("t3");
      send_bit(1'b0, "t3"); gap("t3"); gap("t3"); send_bit(1'b1, "t3"); gap("t3");
      send_bit(1'b0, "t3"); gap("t3"); send_bit(1'b0, "t3"); gap("t3");
      send_bit(1'b1, "t3");
      finish_frame("t3");

      // 4: config write and restart while busy are ignored
      do_cfg(8'b101, 3, 1'b1);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 5);
      send_bit(1'b1, "t4"); send_bit(1'b0, "t4"); send_bit(1'b1, "t4");
      @(posedge clk);
      x_valid = 1'b0; cfg_we = 1'b1; cfg_pat = 8'b11; cfg_len = LW'(2); cfg_ovl = 1'b0;
      start = 1'b1; frame_len = 8'd2;
      #1;
      check("t4_busy_q", 32'(q), 32'd0);
      @(negedge clk); #1;
      cfg_we = 1'b0; start = 1'b0;
      check("t4_still_scan", 32'(dbg_state), 32'(SCAN));
      check("t4_cnt_mid", 32'(match_cnt), 32'(m_cnt));
      send_bit(1'b0, "t4"); send_bit(1'b1, "t4");
      finish_frame("t4");

      // 5: reset mid-frame, then defaults are back
      do_cfg(8'b11, 2, 1'b0);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 5);
      send_bit(1'b1, "t5"); send_bit(1'b1, "t5"); send_bit(1'b1, "t5");
      gap("t5");
      @(posedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      model_cfg(8'(DEF_PAT), DEF_LEN, DEF_OVL);
      m_cnt = 0; m_cnt2 = 0;
      @(negedge clk); #1;
      rst = 1'b1;
      frame_10101("t5_re");

      // 6a: empty frame goes straight to DONE
      begin_frame(1'b0, 8'h00, 0, 1'b0, 0);
      finish_frame("t6_empty");

      // 6b: len 0 clamps to 1, pat 1: every one matches, narrow counter saturates
      do_cfg(8'h01, 0, 1'b1);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 6);
      send_bit(1'b1, "t6b"); send_bit(1'b1, "t6b"); send_bit(1'b0, "t6b");
      send_bit(1'b1, "t6b"); send_bit(1'b1, "t6b"); send_bit(1'b1, "t6b");
      finish_frame("t6b");

      // 6c: len 15 clamps to 8, full-width pattern only matches on the last bit
      do_cfg(8'hAA, 15, 1'b1);
      begin_frame(1'b0, 8'h00, 0, 1'b0, 8);
      for (int i = 0; i < 8; i++) send_bit(1'(~i[0]), "t6c");
      finish_frame("t6c");

      // ---------------- final report ----------------
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
